// File: rtl/data_memory_mmio_if.sv
// Datapath-to-data-memory bus.
//   memwrite   store strobe for the current instruction
//   addr       byte address (datapath aluout)
//   writedata  store data
//   readdata   load data, combinational from addr
// master: datapath side, slave: memory side.
interface data_memory_mmio_if;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output memwrite,
      output addr,
      output writedata,
      input  readdata
   );

   modport slave (
      input  memwrite,
      input  addr,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/data_memory_mmio.sv
// Data-side memory stage: word-addressed data RAM plus a memory-mapped I/O page
// containing an 8N1 serial transmitter (and optionally a free-running cycle counter).
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   bus       data_memory_mmio_if.slave (memwrite, addr, writedata in; readdata out)
//   tx        serial output, idle high (registered)
//   tx_busy   transmitter active (registered)
//
// MMIO page (addr[31:16] == 16'hFFFF), offset addr[15:0]:
//   0x0000 TXDATA  W: writedata[7:0] starts a frame; R: 0
//   0x0004 STATUS  R: {30'b0, ovf, busy}; W: writedata[1]=1 clears ovf
//   0x0008 CYCLES  R: cycle counter (0 unless built with DMEM_CYCLE_COUNTER_EN)
//
// Build option: define DMEM_CYCLE_COUNTER_EN to include the 32-bit cycle counter.
module data_memory_mmio #(
   parameter int unsigned ADDR_W       = 10,
   parameter logic [31:0] RAM_BASE     = 32'h10010000,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                clk,
   input  logic                reset,
   data_memory_mmio_if.slave   bus,
   output logic                tx,
   output logic                tx_busy
);

   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned OFF_W  = 14;

   localparam logic [OFF_W-1:0] OFF_TXDATA = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_CYCLES = OFF_W'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic              mmio_hit;
   logic              ram_hit;
   logic [31:0]       ram_off;
   logic [ADDR_W-1:0] ram_idx;
   logic [OFF_W-1:0]  mmio_word;
   logic              txdata_wr;
   logic              status_wr;
   logic              unused_ok;

   assign mmio_hit  = (bus.addr[31:16] == 16'hFFFF);
   assign ram_off   = bus.addr - RAM_BASE;
   // In range when addr >= base and the offset fits in the RAM window; MMIO wins on overlap.
   assign ram_hit   = !mmio_hit && (bus.addr >= RAM_BASE) && (ram_off[31:ADDR_W+2] == '0);
   assign ram_idx   = ram_off[ADDR_W+1:2];
   assign mmio_word = bus.addr[15:2];
   assign txdata_wr = bus.memwrite && mmio_hit && (mmio_word == OFF_TXDATA);
   assign status_wr = bus.memwrite && mmio_hit && (mmio_word == OFF_STATUS);

   // Byte-lane bits of the offset are don't-care for word access.
   assign unused_ok = ^ram_off[1:0];

   // ------------------------------------------------------------------
   // Data RAM: synchronous write, asynchronous read, contents not reset
   // ------------------------------------------------------------------
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (bus.memwrite && ram_hit) begin
         mem[ram_idx] <= bus.writedata;
      end
   end

   // ------------------------------------------------------------------
   // Serial transmitter FSM
   // ------------------------------------------------------------------
   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        byte_q, byte_d;
   logic              ovf_q, ovf_d;
   logic              tx_d;
   logic              busy_d;
   logic              baud_last;

   assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         ovf_q   <= 1'b0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         ovf_q   <= ovf_d;
         tx      <= tx_d;
         tx_busy <= busy_d;
      end
   end

   // Next-state logic; tx/tx_busy are derived from the next state so the
   // registered pin reflects the state it is in during that cycle.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      ovf_d   = ovf_q;
      tx_d    = 1'b1;
      busy_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (txdata_wr) begin
               state_d = START;
               baud_d  = '0;
               bit_d   = '0;
               byte_d  = bus.writedata[7:0];
            end
         end
         START: begin
            if (baud_last) begin
               state_d = DATA;
               baud_d  = '0;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_last) begin
               state_d = IDLE;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Sticky overflow: any TXDATA write that the FSM could not accept.
      if (txdata_wr && (state_q != IDLE)) begin
         ovf_d = 1'b1;
      end else if (status_wr && bus.writedata[1]) begin
         ovf_d = 1'b0;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = byte_d[bit_d];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // ------------------------------------------------------------------
   // Optional cycle counter
   // ------------------------------------------------------------------
   logic [31:0] cycles_rd;

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycles_q;

   // Free-running, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign cycles_rd = cycles_q;
`else
   assign cycles_rd = '0;
`endif

   // ------------------------------------------------------------------
   // Read mux: purely a function of addr and current state
   // ------------------------------------------------------------------
   always_comb begin
      bus.readdata = '0;
      if (ram_hit) begin
         bus.readdata = mem[ram_idx];
      end else if (mmio_hit) begin
         case (mmio_word)
            OFF_STATUS: bus.readdata = {30'b0, ovf_q, tx_busy};
            OFF_CYCLES: bus.readdata = cycles_rd;
            default:    bus.readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio with CLKS_PER_BIT = 4.
module tb_data_memory_mmio;

   localparam int unsigned CPB      = 4;
   localparam logic [31:0] BASE     = 32'h10010000;
   localparam int unsigned WORDS    = 1024;
   localparam logic [31:0] A_TXDATA = 32'hFFFF0000;
   localparam logic [31:0] A_STATUS = 32'hFFFF0004;
   localparam logic [31:0] A_CYCLES = 32'hFFFF0008;

   logic clk = 1'b0;
   logic reset;
   logic tx;
   logic tx_busy;

   data_memory_mmio_if bus ();

   data_memory_mmio #(
      .ADDR_W       (10),
      .RAM_BASE     (BASE),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboards: expected {busy, tx} per cycle, expected load data per read.
   logic [1:0]  txq [$];
   logic [31:0] rdq [$];

   // Reference model state
   logic [31:0] mem_model [int];
   logic        model_ovf  = 1'b0;
   logic        last_busy  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; compare tx/tx_busy against the scoreboard (idle if empty).
   task automatic tick();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (txq.size() > 0) e = txq.pop_front();
      else                e = 2'b01;
      last_busy = e[1];
      check("txline", {30'b0, tx_busy, tx}, {30'b0, e});
   endtask

   task automatic push_frame(input logic [7:0] b);
      for (int i = 0; i < int'(CPB); i++) txq.push_back(2'b10);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < int'(CPB); i++) txq.push_back({1'b1, b[k]});
      for (int i = 0; i < int'(CPB); i++) txq.push_back(2'b11);
   endtask

   // One store cycle; model updated from the decode as documented.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.memwrite  = 1'b1;
      bus.addr      = a;
      bus.writedata = d;
      if (a[31:16] == 16'hFFFF) begin
         if (a[15:2] == 14'd0) begin
            if (last_busy) model_ovf = 1'b1;
            else           push_frame(d[7:0]);
         end else if (a[15:2] == 14'd1 && d[1]) begin
            model_ovf = 1'b0;
         end
      end else if (a >= BASE && a < BASE + 4 * WORDS) begin
         mem_model[int'((a - BASE) >> 2)] = d;
      end
      tick();
      bus.memwrite = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.memwrite = 1'b0;
      bus.addr     = a;
      rdq.push_back(exp);
      #1;
      check(tag, bus.readdata, rdq.pop_front());
   endtask

   function automatic logic [31:0] ram_exp(input logic [31:0] a);
      return mem_model[int'((a - BASE) >> 2)];
   endfunction

   function automatic logic [31:0] status_exp();
      return {30'b0, model_ovf, last_busy};
   endfunction

   initial begin
      reset         = 1'b1;
      bus.memwrite  = 1'b0;
      bus.addr      = 32'h0;
      bus.writedata = 32'h0;

      // Reset state
      repeat (3) tick();
      rd("status_reset", A_STATUS, 32'h0);
      reset = 1'b0;

      // Cycle counter 100 cycles after reset release
      repeat (100) tick();
`ifdef DMEM_CYCLE_COUNTER_EN
      rd("cycles", A_CYCLES, 32'd100);
`else
      rd("cycles", A_CYCLES, 32'd0);
`endif

      // RAM basics and boundaries
      bus_write(BASE + 32'h0, 32'h12345678);
      bus_write(BASE + 32'h4, 32'hDEADBEEF);
      rd("ram_w1", BASE + 32'h4, ram_exp(BASE + 32'h4));
      rd("ram_w0", BASE + 32'h0, ram_exp(BASE + 32'h0));
      rd("ram_w1_lane", BASE + 32'h7, ram_exp(BASE + 32'h4));

      // Read during write cycle returns old data
      bus.memwrite  = 1'b1;
      bus.addr      = BASE + 32'h4;
      bus.writedata = 32'hCAFEF00D;
      #1;
      check("ram_old_in_wr", bus.readdata, 32'hDEADBEEF);
      bus.memwrite  = 1'b0;
      bus_write(BASE + 32'h4, 32'hCAFEF00D);
      rd("ram_new", BASE + 32'h4, ram_exp(BASE + 32'h4));

      bus_write(BASE + 32'hFFC, 32'hA1B2C3D4);
      rd("ram_top", BASE + 32'hFFC, ram_exp(BASE + 32'hFFC));
      bus_write(BASE + 32'h1000, 32'h0BADF00D);
      rd("past_top", BASE + 32'h1000, 32'h0);
      rd("no_alias", BASE + 32'h0, ram_exp(BASE + 32'h0));
      bus_write(32'h00000010, 32'h55555555);
      rd("unmapped", 32'h00000010, 32'h0);
      rd("below_base", BASE - 32'h4, 32'h0);
      rd("ram_intact", BASE + 32'h4, ram_exp(BASE + 32'h4));
      rd("mmio_other", 32'hFFFF000C, 32'h0);
      rd("txdata_rd", A_TXDATA, 32'h0);

      // Frame 0xA5
      bus_write(A_TXDATA, 32'h000000A5);
      rd("status_busy", A_STATUS, status_exp());
      repeat (44) tick();
      rd("status_idle", A_STATUS, status_exp());

      // Overflow: 0x41 then 0x42 in frame cycle 10
      bus_write(A_TXDATA, 32'h00000041);
      repeat (8) tick();
      bus_write(A_TXDATA, 32'h00000042);
      rd("status_ovf", A_STATUS, status_exp());
      check("status_ovf_val", bus.readdata, 32'h3);
      bus_write(A_STATUS, 32'h00000002);
      rd("status_clr", A_STATUS, status_exp());
      check("status_clr_val", bus.readdata, 32'h1);
      repeat (35) tick();

      // Write in the last STOP cycle is dropped
      bus_write(A_TXDATA, 32'h00000055);
      repeat (39) tick();
      bus_write(A_TXDATA, 32'h00000066);
      repeat (3) tick();
      rd("status_b2b", A_STATUS, status_exp());
      bus_write(A_STATUS, 32'h00000002);
      rd("status_b2b_clr", A_STATUS, status_exp());

      // Reset mid-frame, then a clean frame
      bus_write(A_TXDATA, 32'h0000003C);
      repeat (14) tick();
      bus_write(A_TXDATA, 32'h00000000);
      txq.delete();
      model_ovf = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd("status_after_rst", A_STATUS, status_exp());
      tick();
      bus_write(A_TXDATA, 32'h0000005A);
      repeat (44) tick();
      rd("status_final", A_STATUS, status_exp());
      check("txq_drained", 32'(txq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
